tof_capture: RTL and testbench

- Time-of-flight capture stage downstream of the SonarOnChip channel array.
- Consumes the per-channel `cmp` threshold outputs and timestamps the first rising edge of each channel after a start event, counted in `ce_pcm` ticks.
- Exposes results through the same 4-bit-address / 16-bit-data local bus used by the channel instances, with a `hi_z` bus-release flag and a done interrupt.

---
 rtl/tof_capture_if.sv | 25 ++
 rtl/tof_capture.sv | 196 +++++++++++++++++++
 tb/tb_tof_capture.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tof_capture_if.sv
// Local bus between a host and tof_capture: 4-bit word address, 16-bit data,
// one-cycle ack and a bus-release flag.
interface tof_capture_if;
  // Handshake: the master holds wb_valid_i high for exactly one cycle per access.
  // There is no back-pressure. The slave returns wbs_ack_o exactly one cycle later
  // for one cycle. wbs_dat_o carries read data in that cycle and is 0 at all other
  // times. hi_z is low only in that cycle.
  logic        wb_valid_i;
  logic [3:0]  wbs_adr_i;
  logic [15:0] wbs_dat_i;
  logic        wbs_strb_i;
  logic        wbs_ack_o;
  logic [15:0] wbs_dat_o;
  logic        hi_z;

  modport master (
    output wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
    input  wbs_ack_o, wbs_dat_o, hi_z
  );

  modport slave (
    input  wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
    output wbs_ack_o, wbs_dat_o, hi_z
  );
endinterface

// File: rtl/tof_capture.sv
// Time-of-flight capture: timestamps the first rising edge per comparator channel after start.
// Define TOF_DEBOUNCE_EN to qualify hits by a 0-1-1 pattern on consecutive ce_pcm samples.
module tof_capture #(
  parameter int N_CH  = 15,
  parameter int CNT_W = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  tof_capture_if.slave    bus,
  input  logic            ce_pcm,
  input  logic            start_i,
  input  logic [N_CH-1:0] cmp,
  output logic            irq,
  output logic [1:0]      dbg_state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [N_CH-1:0]  hit_q, hit_d;
  logic [N_CH-1:0]  fire;
  logic [CNT_W-1:0] cap_q [N_CH];
  logic [CNT_W-1:0] cap_d [N_CH];
  logic             done_q, done_d, tmo_q, tmo_d;
  logic             irq_en_q, irq_en_d, irq_q, irq_d;
  logic [3:0]       sel_q, sel_d;
  logic             ack_q, ack_d, hi_z_q, hi_z_d;
  logic [15:0]      dat_q, dat_d;
  logic             wr, rd, start;
`ifdef TOF_DEBOUNCE_EN
  // Per-channel sample history: 0 = nothing useful, 1 = low seen, 2 = low then high.
  logic [1:0]       stg_q  [N_CH];
  logic [1:0]       stg_d  [N_CH];
  logic [CNT_W-1:0] pend_q [N_CH];
  logic [CNT_W-1:0] pend_d [N_CH];
`else
  logic [N_CH-1:0]  cmp_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    hit_d     = hit_q;
    cap_d     = cap_q;
    done_d    = done_q;
    tmo_d     = tmo_q;
    irq_en_d  = irq_en_q;
    sel_d     = sel_q;
    irq_d     = done_q & irq_en_q;
    wr        = bus.wb_valid_i & bus.wbs_strb_i;
    rd        = bus.wb_valid_i & ~bus.wbs_strb_i;
    start     = start_i | (wr & (bus.wbs_adr_i == 4'd0) & bus.wbs_dat_i[0]);
    ack_d     = bus.wb_valid_i;
    hi_z_d    = ~bus.wb_valid_i;
    dat_d     = '0;

    if (rd) begin
      case (bus.wbs_adr_i)
        4'd0: dat_d = {14'b0, irq_en_q, 1'b0};
        4'd1: dat_d = {13'b0, tmo_q, done_q, state_q == RUN};
        4'd2: dat_d = 16'(timeout_q);
        4'd3: dat_d = 16'(hit_q);
        4'd4: dat_d = {12'b0, sel_q};
        4'd5: if (int'(sel_q) < N_CH) dat_d = 16'(cap_q[sel_q]);
        default: dat_d = '0;
      endcase
    end

    if (wr) begin
      case (bus.wbs_adr_i)
        4'd0: irq_en_d  = bus.wbs_dat_i[1];
        4'd2: timeout_d = CNT_W'(bus.wbs_dat_i);
        4'd4: sel_d     = bus.wbs_dat_i[3:0];
        default: ;
      endcase
    end

`ifdef TOF_DEBOUNCE_EN
    stg_d  = stg_q;
    pend_d = pend_q;
    fire   = '0;
    for (int i = 0; i < N_CH; i++) fire[i] = ce_pcm & (stg_q[i] == 2'd2) & cmp[i];
`else
    fire = cmp & ~cmp_q;
`endif

    if (start) begin
      state_d = RUN;
      cnt_d   = '0;
      hit_d   = '0;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      for (int i = 0; i < N_CH; i++) cap_d[i] = '0;
`ifdef TOF_DEBOUNCE_EN
      for (int i = 0; i < N_CH; i++) begin
        stg_d[i]  = 2'd0;
        pend_d[i] = '0;
      end
`endif
    end else begin
      if (state_q == RUN) begin
        for (int i = 0; i < N_CH; i++) begin
          if (fire[i] && !hit_q[i]) begin
            hit_d[i] = 1'b1;
`ifdef TOF_DEBOUNCE_EN
            cap_d[i] = pend_q[i];
`else
            cap_d[i] = cnt_q;
`endif
          end
`ifdef TOF_DEBOUNCE_EN
          if (ce_pcm) begin
            if (stg_q[i] == 2'd2) stg_d[i] = cmp[i] ? 2'd0 : 2'd1;
            else if (!cmp[i]) stg_d[i] = 2'd1;
            else if (stg_q[i] == 2'd1) begin
              stg_d[i]  = 2'd2;
              pend_d[i] = cnt_q;
            end
          end
`endif
        end
        // Completing the mask wins over a timeout landing in the same cycle.
        if (&hit_d) begin
          state_d = DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b0;
        end else if (ce_pcm && cnt_q == timeout_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end
        if (ce_pcm && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
      if (wr && bus.wbs_adr_i == 4'd1 && state_q == DONE) begin
        state_d = IDLE;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= '1;
      hit_q     <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      sel_q     <= '0;
      ack_q     <= 1'b0;
      hi_z_q    <= 1'b1;
      dat_q     <= '0;
      for (int i = 0; i < N_CH; i++) cap_q[i] <= '0;
`ifdef TOF_DEBOUNCE_EN
      for (int i = 0; i < N_CH; i++) begin
        stg_q[i]  <= 2'd0;
        pend_q[i] <= '0;
      end
`else
      cmp_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      hit_q     <= hit_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      hi_z_q    <= hi_z_d;
      dat_q     <= dat_d;
      cap_q     <= cap_d;
`ifdef TOF_DEBOUNCE_EN
      stg_q     <= stg_d;
      pend_q    <= pend_d;
`else
      cmp_q     <= cmp;
`endif
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.hi_z      = hi_z_q;
  assign irq           = irq_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_tof_capture.sv
// Bench for tof_capture: directed bus/tick/cmp stimulus, a cycle model of the
// register-level behaviour, a per-cycle output compare and literal pins.
module tb_tof_capture;
  localparam int N = 15;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         ce_pcm   = 1'b0;
  logic         start_i  = 1'b0;
  logic [N-1:0] cmp      = '0;
  logic         irq;
  logic [1:0]   dbg_state;

  tof_capture_if bus_if ();

  tof_capture #(.N_CH(N), .CNT_W(16)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .bus         (bus_if.slave),
    .ce_pcm      (ce_pcm),
    .start_i     (start_i),
    .cmp         (cmp),
    .irq         (irq),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          live = 0;
  bit          m_run, m_done, m_to, m_irq_en, was_done, st, fire_i, wr_m;
  int          m_cnt, m_tmo, m_sel, rv, cv;
  bit          m_hit  [N];
  bit          m_prev [N];
  int          m_cap  [N];
  int          m_old  [N];
  int          m_mid  [N];
  int          m_midc [N];
  logic        exp_ack, exp_hiz, exp_irq;
  logic [15:0] exp_dat;

  function automatic int hit_mask();
    int m = 0;
    for (int i = 0; i < N; i++) if (m_hit[i]) m |= (1 << i);
    return m;
  endfunction

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      m_run = 0; m_done = 0; m_to = 0; m_cnt = 0; m_tmo = 16'hFFFF; m_irq_en = 0; m_sel = 0;
      for (int i = 0; i < N; i++) begin
        m_cap[i] = 0; m_hit[i] = 0; m_prev[i] = 0; m_old[i] = -1; m_mid[i] = -1; m_midc[i] = 0;
      end
      exp_ack = 0; exp_hiz = 1; exp_dat = 0; exp_irq = 0;
    end else begin
      was_done = m_done;
      exp_irq  = m_done & m_irq_en;
      wr_m     = bus_if.wb_valid_i & bus_if.wbs_strb_i;
      rv = 0;
      if (bus_if.wb_valid_i && !bus_if.wbs_strb_i) begin
        case (bus_if.wbs_adr_i)
          4'd0: rv = m_irq_en ? 2 : 0;
          4'd1: rv = (m_run ? 1 : 0) + (m_done ? 2 : 0) + (m_to ? 4 : 0);
          4'd2: rv = m_tmo;
          4'd3: rv = hit_mask();
          4'd4: rv = m_sel;
          4'd5: rv = (m_sel < N) ? m_cap[m_sel] : 0;
          default: rv = 0;
        endcase
      end
      exp_ack = bus_if.wb_valid_i;
      exp_hiz = !bus_if.wb_valid_i;
      exp_dat = 16'(rv);
      st = start_i || (wr_m && bus_if.wbs_adr_i == 4'd0 && bus_if.wbs_dat_i[0]);
      if (st) begin
        m_run = 1; m_done = 0; m_to = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) begin
          m_hit[i] = 0; m_cap[i] = 0; m_old[i] = -1; m_mid[i] = -1;
        end
      end else begin
        if (m_run) begin
          for (int i = 0; i < N; i++) begin
`ifdef TOF_DEBOUNCE_EN
            fire_i = 0; cv = 0;
            if (ce_pcm) begin
              if (m_old[i] == 0 && m_mid[i] == 1 && cmp[i]) begin fire_i = 1; cv = m_midc[i]; end
              m_old[i] = m_mid[i]; m_mid[i] = cmp[i] ? 1 : 0; m_midc[i] = m_cnt;
            end
`else
            fire_i = cmp[i] && !m_prev[i];
            cv     = m_cnt;
`endif
            if (fire_i && !m_hit[i]) begin m_hit[i] = 1; m_cap[i] = cv; end
          end
          if (hit_mask() == (1 << N) - 1) begin
            m_run = 0; m_done = 1; m_to = 0;
          end else if (ce_pcm && m_cnt == m_tmo) begin
            m_run = 0; m_done = 1; m_to = 1;
          end
          if (ce_pcm && m_cnt < 65535) m_cnt++;
        end
        if (wr_m && bus_if.wbs_adr_i == 4'd1 && was_done) begin
          m_done = 0; m_to = 0;
        end
      end
      if (wr_m) begin
        case (bus_if.wbs_adr_i)
          4'd0: m_irq_en = bus_if.wbs_dat_i[1];
          4'd2: m_tmo    = bus_if.wbs_dat_i;
          4'd4: m_sel    = bus_if.wbs_dat_i[3:0];
          default: ;
        endcase
      end
      for (int i = 0; i < N; i++) m_prev[i] = cmp[i];
      live = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge wb_clk_i) begin
    if (live) begin
      chk("ack",   bus_if.wbs_ack_o, exp_ack);
      chk("hi_z",  bus_if.hi_z,      exp_hiz);
      chk("rdata", bus_if.wbs_dat_o, exp_dat);
      chk("irq",   irq,              exp_irq);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge wb_clk_i);
    bus_if.wb_valid_i = 1; bus_if.wbs_strb_i = 1; bus_if.wbs_adr_i = a; bus_if.wbs_dat_i = d;
    @(negedge wb_clk_i);
    bus_if.wb_valid_i = 0; bus_if.wbs_strb_i = 0; bus_if.wbs_dat_i = '0;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [15:0] exp, input string name);
    @(negedge wb_clk_i);
    bus_if.wb_valid_i = 1; bus_if.wbs_strb_i = 0; bus_if.wbs_adr_i = a; bus_if.wbs_dat_i = '0;
    @(negedge wb_clk_i);
    bus_if.wb_valid_i = 0;
    chk(name, bus_if.wbs_dat_o, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge wb_clk_i); ce_pcm = 1;
      @(negedge wb_clk_i); ce_pcm = 0;
      @(negedge wb_clk_i);
      @(negedge wb_clk_i);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus_if.wb_valid_i = 0; bus_if.wbs_strb_i = 0; bus_if.wbs_adr_i = '0; bus_if.wbs_dat_i = '0;
    repeat (3) @(negedge wb_clk_i);
    chk("rst_ack",  bus_if.wbs_ack_o, 0);
    chk("rst_hiz",  bus_if.hi_z,      1);
    chk("rst_dat",  bus_if.wbs_dat_o, 0);
    chk("rst_irq",  irq,              0);
    wb_rst_i = 0;
    bus_rd(4'd1, 16'h0000, "rst_status");
    bus_rd(4'd2, 16'hFFFF, "rst_timeout");
    bus_rd(4'd3, 16'h0000, "rst_hit");

`ifdef TOF_DEBOUNCE_EN
    bus_wr(4'd2, 16'd100);
    bus_wr(4'd0, 16'h0001);
    tick(5);
    cmp[2] = 1; tick(1);
    cmp[2] = 0; tick(6);
    bus_rd(4'd3, 16'h0000, "dbc_glitch_hit");
    cmp[2] = 1; tick(2);
    bus_rd(4'd3, 16'h0004, "dbc_hit");
    bus_wr(4'd4, 16'd2);
    bus_rd(4'd5, 16'd12,   "dbc_tof2");
    bus_rd(4'd1, 16'h0001, "dbc_busy");
`else
    // Full capture run with irq enabled.
    bus_wr(4'd2, 16'd100);
    bus_wr(4'd0, 16'h0003);
    tick(10);
    cmp[3] = 1;
    tick(10);
    cmp = '1;
    bus_rd(4'd1, 16'h0002, "a_status");
    chk("a_irq", irq, 1);
    bus_rd(4'd3, 16'h7FFF, "a_hit");
    bus_wr(4'd4, 16'd3);
    bus_rd(4'd5, 16'd10, "a_tof3");
    bus_wr(4'd4, 16'd0);
    bus_rd(4'd5, 16'd20, "a_tof0");
    bus_wr(4'd4, 16'd14);
    bus_rd(4'd5, 16'd20, "a_tof14");

    // Clearing done drops irq one cycle later.
    bus_wr(4'd1, 16'h0000);
    chk("b_irq_hold", irq, 1);
    @(negedge wb_clk_i);
    chk("b_irq_fall", irq, 0);
    bus_rd(4'd1, 16'h0000, "b_idle");
    bus_wr(4'd0, 16'h0000);
    cmp = '0;

    // Timeout with no activity.
    bus_wr(4'd2, 16'd5);
    @(negedge wb_clk_i); start_i = 1;
    @(negedge wb_clk_i); start_i = 0;
    tick(5);
    bus_rd(4'd1, 16'h0001, "c_busy");
    tick(1);
    bus_rd(4'd1, 16'h0006, "c_timeout");
    bus_rd(4'd3, 16'h0000, "c_hit");
    chk("c_irq", irq, 0);

    // TIMEOUT=0 ends on the first tick.
    bus_wr(4'd2, 16'd0);
    bus_wr(4'd0, 16'h0001);
    bus_rd(4'd1, 16'h0001, "t0_busy");
    tick(1);
    bus_rd(4'd1, 16'h0006, "t0_done");

    // Channel high across start only hits on a fresh rising edge.
    cmp[0] = 1;
    bus_wr(4'd2, 16'd100);
    bus_wr(4'd0, 16'h0001);
    tick(7);
    cmp[0] = 0;
    @(negedge wb_clk_i); cmp[0] = 1;
    tick(2);
    cmp[0] = 0;
    @(negedge wb_clk_i); cmp[0] = 1;
    bus_wr(4'd4, 16'd0);
    bus_rd(4'd5, 16'd7,    "d_tof0");
    bus_rd(4'd3, 16'h0001, "d_hit");

    // Restart mid-run at tick 30, then prove the counter restarted.
    tick(21);
    bus_wr(4'd0, 16'h0001);
    bus_rd(4'd3, 16'h0000, "e_hit");
    bus_rd(4'd5, 16'd0,    "e_tof0");
    bus_rd(4'd1, 16'h0001, "e_busy");
    bus_wr(4'd2, 16'd3);
    tick(3);
    bus_rd(4'd1, 16'h0001, "e_busy3");
    tick(1);
    bus_rd(4'd1, 16'h0006, "e_timeout");
    bus_wr(4'd1, 16'h0000);
    bus_rd(4'd1, 16'h0000, "e_idle");

    // Register file corners.
    bus_wr(4'd4, 16'd15);
    bus_rd(4'd4, 16'd15,   "f_sel");
    bus_rd(4'd5, 16'd0,    "f_tof15");
    bus_wr(4'd7, 16'hABCD);
    bus_rd(4'd7, 16'h0000, "f_unmapped");
    bus_rd(4'd2, 16'd3,    "f_timeout");
    bus_wr(4'd0, 16'h0002);
    bus_rd(4'd0, 16'h0002, "f_ctrl");
    bus_rd(4'd1, 16'h0000, "f_status");
`endif

    repeat (3) @(negedge wb_clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
